// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Load/store sequencer between the MEM pipeline stage and the
//            data-memory port. Accepts one load/store at a time, checks
//            alignment, drives a req/ack handshake to dmem, positions store
//            data on byte lanes, aligns load data for write-back, and stalls
//            the pipeline until the access has completed.
//
// Ports    :
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mem_valid           MEM stage holds a load/store (stable while stall=1)
//   mem_store           1 = store, 0 = load
//   ld_sel[2:0]         0 LB, 1 LH, 2 LWL, 3 LW, 4 LBU, 5 LHU, 6 LWR
//   st_sel[2:0]         0 SB, 1 SH, 2 SWL, 3 SW, 4 SWR
//   mem_addr            effective byte address
//   mem_wdata[31:0]     store data (rt)
//   stall               freeze pipeline
//   wb_valid            1-cycle pulse, ld_data/ld_be valid
//   ld_data[31:0]       aligned load result (held between pulses)
//   ld_be[3:0]          register byte-write enables (held between pulses)
//   addr_err            1-cycle pulse, misaligned access, no dmem access
//   bus_err             1-cycle pulse, ack timeout (0 unless timeout enabled)
//   dmem_req/we         memory request / write strobe
//   dmem_addr           word address, bits [1:0] = 0
//   dmem_be[3:0]        byte lanes
//   dmem_wdata[31:0]    lane-positioned store data
//   dmem_ack            completion, sampled only while dmem_req = 1
//   dmem_rdata[31:0]    read data, valid with dmem_ack on loads
//
// Build option : define LSU_TIMEOUT_EN to enable the ack timeout counter
//                (TIMEOUT_CYCLES REQ cycles without ack -> bus_err).
//
// Revision : 1.0 - initial release
// ============================================================================

module lsu_mem_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic              mem_store,
    input  logic [2:0]        ld_sel,
    input  logic [2:0]        st_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [31:0]       ld_data,
    output logic [3:0]        ld_be,
    output logic              addr_err,
    output logic              bus_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    // ------------------------------------------------------------------
    // Operation encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] C_LD_LB  = 3'd0;
    localparam logic [2:0] C_LD_LH  = 3'd1;
    localparam logic [2:0] C_LD_LWL = 3'd2;
    localparam logic [2:0] C_LD_LW  = 3'd3;
    localparam logic [2:0] C_LD_LBU = 3'd4;
    localparam logic [2:0] C_LD_LHU = 3'd5;
    localparam logic [2:0] C_LD_LWR = 3'd6;

    localparam logic [2:0] C_ST_SB  = 3'd0;
    localparam logic [2:0] C_ST_SH  = 3'd1;
    localparam logic [2:0] C_ST_SWL = 3'd2;
    localparam logic [2:0] C_ST_SW  = 3'd3;
    localparam logic [2:0] C_ST_SWR = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // FSM decode strobes
    logic w_stall;
    logic w_accept;      // aligned op taken in IDLE
    logic w_reject;      // misaligned op seen in IDLE
    logic w_ack_done;    // ack received in REQ
    logic w_timeout;     // REQ abandoned by the timeout counter
    logic w_cnt_expired;

    // Request-side combinational data
    logic [1:0]  w_lo;
    logic        w_misaligned;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;

    // Latched request
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [3:0]        r_dmem_be;
    logic [31:0]       r_dmem_wdata;
    logic              r_is_store;
    logic [2:0]        r_ld_sel;
    logic [1:0]        r_lo;

    // Load result
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic [3:0]  w_ld_be;
    logic        r_wb_valid;
    logic [31:0] r_ld_data;
    logic [3:0]  r_ld_be;
    logic        r_addr_err;

    assign w_lo = mem_addr[1:0];

    // ------------------------------------------------------------------
    // Alignment check: only halfword and full-word accesses constrain the
    // low address bits; byte and unaligned-word (LWL/LWR/SWL/SWR) ops never
    // fault.
    // ------------------------------------------------------------------
    always_comb begin
        w_misaligned = 1'b0;
        if (mem_store) begin
            case (st_sel)
                C_ST_SH: w_misaligned = w_lo[0];
                C_ST_SW: w_misaligned = |w_lo;
                default: w_misaligned = 1'b0;
            endcase
        end else begin
            case (ld_sel)
                C_LD_LH,
                C_LD_LHU: w_misaligned = w_lo[0];
                C_LD_LW:  w_misaligned = |w_lo;
                default:  w_misaligned = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store lane generation. For SWR the shift is 3-a, which on a 2-bit
    // offset is simply its bitwise inverse.
    // ------------------------------------------------------------------
    always_comb begin
        w_st_be   = 4'b1111;
        w_st_data = mem_wdata;
        case (st_sel)
            C_ST_SB: begin
                w_st_data = {4{mem_wdata[7:0]}};
                w_st_be   = 4'b0001 << w_lo;
            end
            C_ST_SH: begin
                w_st_data = {2{mem_wdata[15:0]}};
                w_st_be   = w_lo[1] ? 4'b1100 : 4'b0011;
            end
            C_ST_SWL: begin
                w_st_data = mem_wdata >> {w_lo, 3'b000};
                w_st_be   = 4'b1111 >> w_lo;
            end
            C_ST_SWR: begin
                w_st_data = mem_wdata << {~w_lo, 3'b000};
                w_st_be   = 4'b1111 << ~w_lo;
            end
            default: begin
                w_st_be   = 4'b1111;
                w_st_data = mem_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load alignment, computed from the latched op and the live read data
    // so the result can be registered on the ack cycle.
    // ------------------------------------------------------------------
    assign w_byte = 8'(dmem_rdata >> {r_lo, 3'b000});
    assign w_half = r_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_ld_data = dmem_rdata;
        w_ld_be   = 4'b1111;
        case (r_ld_sel)
            C_LD_LB:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            C_LD_LBU: w_ld_data = {24'h000000, w_byte};
            C_LD_LH:  w_ld_data = {{16{w_half[15]}}, w_half};
            C_LD_LHU: w_ld_data = {16'h0000, w_half};
            C_LD_LWL: begin
                w_ld_data = dmem_rdata << {r_lo, 3'b000};
                w_ld_be   = 4'b1111 << r_lo;
            end
            C_LD_LWR: begin
                w_ld_data = dmem_rdata >> {~r_lo, 3'b000};
                w_ld_be   = 4'b1111 >> ~r_lo;
            end
            default: begin
                w_ld_data = dmem_rdata;
                w_ld_be   = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Optional ack timeout
    // ------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
    localparam int C_CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int C_CNT_W   = (C_CNT_RAW < 8)  ? 8  :
                               (C_CNT_RAW > 32) ? 32 : C_CNT_RAW;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_bus_err;

    // r_cnt equals the index of the current REQ cycle, so the request
    // expires at the end of REQ cycle TIMEOUT_CYCLES-1.
    assign w_cnt_expired = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ && w_state_next == S_REQ) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_cnt_expired = 1'b0;
    assign bus_err       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = mem_valid;
                if (mem_valid) begin
                    if (w_misaligned) begin
                        w_reject     = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_accept     = 1'b1;
                        w_state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                // An ack on the final allowed cycle still completes normally.
                if (dmem_ack) begin
                    w_ack_done   = 1'b1;
                    w_state_next = S_DONE;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // mem_valid is still the completed op here; never re-accept it.
                w_stall      = 1'b0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, handshake and write-back registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= 4'b0000;
            r_dmem_wdata <= 32'h0000_0000;
            r_is_store   <= 1'b0;
            r_ld_sel     <= 3'd0;
            r_lo         <= 2'd0;
            r_wb_valid   <= 1'b0;
            r_ld_data    <= 32'h0000_0000;
            r_ld_be      <= 4'b0000;
            r_addr_err   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_addr_err <= w_reject;

            if (w_accept) begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= mem_store;
                r_dmem_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                // Loads fetch the whole word; alignment happens on return.
                r_dmem_be    <= mem_store ? w_st_be : 4'b1111;
                r_dmem_wdata <= mem_store ? w_st_data : 32'h0000_0000;
                r_is_store   <= mem_store;
                r_ld_sel     <= ld_sel;
                r_lo         <= w_lo;
            end

            if (w_ack_done || w_timeout) begin
                r_dmem_req <= 1'b0;
                r_dmem_we  <= 1'b0;
            end

            if (w_ack_done && !r_is_store) begin
                r_wb_valid <= 1'b1;
                r_ld_data  <= w_ld_data;
                r_ld_be    <= w_ld_be;
            end
        end
    end

    assign stall      = w_stall;
    assign wb_valid   = r_wb_valid;
    assign ld_data    = r_ld_data;
    assign ld_be      = r_ld_be;
    assign addr_err   = r_addr_err;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_be    = r_dmem_be;
    assign dmem_wdata = r_dmem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Self-checking bench for lsu_mem_ctrl. A transaction-level model
//            predicts every cycle of each load/store (stall, handshake,
//            lanes, write-back) and one compare process checks the DUT
//            against it each cycle. Honours LSU_TIMEOUT_EN (timeout = 4).
// Revision : 1.0 - initial release
// ============================================================================

module tb_lsu_mem_ctrl;

`ifdef LSU_TIMEOUT_EN
    localparam int T_TO     = 4;
    localparam int MAX_WAIT = 6;
`else
    localparam int T_TO     = 255;
    localparam int MAX_WAIT = 5;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_store;
    logic [2:0]  ld_sel;
    logic [2:0]  st_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        wb_valid;
    logic [31:0] ld_data;
    logic [3:0]  ld_be;
    logic        addr_err;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    lsu_mem_ctrl #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (T_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_valid  (mem_valid),
        .mem_store  (mem_store),
        .ld_sel     (ld_sel),
        .st_sel     (st_sel),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .ld_data    (ld_data),
        .ld_be      (ld_be),
        .addr_err   (addr_err),
        .bus_err    (bus_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        wb_valid;
        logic        addr_err;
        logic        bus_err;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld_data;
        logic [3:0]  ld_be;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          req_cycles = 0;
    logic [31:0] m_ld_data = 32'h0;
    logic [3:0]  m_ld_be   = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit model_misaligned(input bit st, input logic [2:0] sel, input logic [31:0] a);
        int k;
        k = int'(a[1:0]);
        if (st) return (sel == 3'd1 && (k % 2) != 0) || (sel == 3'd3 && k != 0);
        return ((sel == 3'd1 || sel == 3'd5) && (k % 2) != 0) || (sel == 3'd3 && k != 0);
    endfunction

    function automatic void model_store(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] w,
                                        output logic [3:0] be, output logic [31:0] d);
        int k;
        k = int'(a[1:0]);
        case (sel)
            3'd0: begin d = {4{w[7:0]}};  be = 4'(1 << k); end
            3'd1: begin d = {2{w[15:0]}}; be = (k >= 2) ? 4'b1100 : 4'b0011; end
            3'd2: begin d = w >> (8 * k); be = 4'(15 >> k); end
            3'd4: begin d = w << (8 * (3 - k)); be = 4'((15 << (3 - k)) & 15); end
            default: begin d = w; be = 4'b1111; end
        endcase
    endfunction

    function automatic void model_load(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] r,
                                       output logic [31:0] d, output logic [3:0] be);
        int k;
        logic [7:0]  b;
        logic [15:0] h;
        logic [3:0]  lwl_t [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
        logic [3:0]  lwr_t [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        k  = int'(a[1:0]);
        b  = r[8*k +: 8];
        h  = r[16*(k/2) +: 16];
        be = 4'b1111;
        case (sel)
            3'd0: d = (b >= 8'h80) ? 32'(b) - 32'd256 : 32'(b);
            3'd4: d = 32'(b);
            3'd1: d = (h >= 16'h8000) ? 32'(h) - 32'h10000 : 32'(h);
            3'd5: d = 32'(h);
            3'd2: begin d = r << (8 * k);       be = lwl_t[k]; end
            3'd6: begin d = r >> (8 * (3 - k)); be = lwr_t[k]; end
            default: d = r;
        endcase
    endfunction

    function automatic exp_t base();
        exp_t e;
        e = '{default: '0};
        e.ld_data = m_ld_data;
        e.ld_be   = m_ld_be;
        return e;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (dmem_req === 1'b1) req_cycles++;
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("stall",    32'(stall),    32'(ce.stall));
            chk("wb_valid", 32'(wb_valid), 32'(ce.wb_valid));
            chk("addr_err", 32'(addr_err), 32'(ce.addr_err));
            chk("bus_err",  32'(bus_err),  32'(ce.bus_err));
            chk("dmem_req", 32'(dmem_req), 32'(ce.req));
            chk("ld_data",  ld_data,       ce.ld_data);
            chk("ld_be",    32'(ld_be),    32'(ce.ld_be));
            if (ce.req) begin
                chk("dmem_addr", dmem_addr,     ce.addr);
                chk("dmem_we",   32'(dmem_we),  32'(ce.we));
                if (ce.we) begin
                    chk("dmem_be",    32'(dmem_be), 32'(ce.be));
                    chk("dmem_wdata", dmem_wdata,   ce.wdata);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic st, input logic [2:0] ls, input logic [2:0] ss,
                        input logic [31:0] a, input logic [31:0] w, input logic ack,
                        input logic [31:0] rd, input exp_t e);
        @(posedge clk);
        #1;
        mem_valid  = v;
        mem_store  = st;
        ld_sel     = ls;
        st_sel     = ss;
        mem_addr   = a;
        mem_wdata  = w;
        dmem_ack   = ack;
        dmem_rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom), 3'($urandom), 3'($urandom), $urandom, $urandom,
                 1'($urandom), $urandom, base());
    endtask

    task automatic do_op(input bit st, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] w, input int wait_n, input logic [31:0] rd);
        exp_t        e;
        bit          to;
        int          nreq;
        logic [3:0]  sbe;
        logic [31:0] sd;
        logic [31:0] ld;
        logic [3:0]  lbe;
        logic [2:0]  ls;
        logic [2:0]  ss;
        ls = st ? 3'($urandom) : sel;
        ss = st ? sel : 3'($urandom);
        model_store(sel, a, w, sbe, sd);
        model_load(sel, a, rd, ld, lbe);

        e = base();
        e.stall = 1'b1;
        step(1'b1, st, ls, ss, a, w, 1'($urandom), $urandom, e);

        if (model_misaligned(st, sel, a)) begin
            e = base();
            e.addr_err = 1'b1;
            step(1'b1, st, ls, ss, a, w, 1'($urandom), $urandom, e);
            return;
        end

        to   = (wait_n >= T_TO);
        nreq = to ? T_TO : wait_n + 1;
        for (int k = 0; k < nreq; k++) begin
            e = base();
            e.stall = 1'b1;
            e.req   = 1'b1;
            e.we    = st;
            e.addr  = {a[31:2], 2'b00};
            e.be    = sbe;
            e.wdata = sd;
            if (!to && k == wait_n) step(1'b1, st, ls, ss, a, w, 1'b1, rd, e);
            else                    step(1'b1, st, ls, ss, a, w, 1'b0, $urandom, e);
        end

        if (!st && !to) begin
            m_ld_data = ld;
            m_ld_be   = lbe;
        end
        e = base();
        e.wb_valid = !st && !to;
        e.bus_err  = to;
        step(1'b1, st, ls, ss, a, w, 1'($urandom), $urandom, e);
    endtask

    logic [31:0] pd;
    logic [3:0]  pb;
    int          r0;

    initial begin
        rst_n = 1'b0; mem_valid = 1'b0; mem_store = 1'b0; ld_sel = 3'd0; st_sel = 3'd0;
        mem_addr = 32'h0; mem_wdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;

        @(negedge clk);
        chk("rst_stall",      32'(stall),    32'h0);
        chk("rst_wb_valid",   32'(wb_valid), 32'h0);
        chk("rst_ld_data",    ld_data,       32'h0);
        chk("rst_ld_be",      32'(ld_be),    32'h0);
        chk("rst_addr_err",   32'(addr_err), 32'h0);
        chk("rst_bus_err",    32'(bus_err),  32'h0);
        chk("rst_dmem_req",   32'(dmem_req), 32'h0);
        chk("rst_dmem_we",    32'(dmem_we),  32'h0);
        chk("rst_dmem_addr",  dmem_addr,     32'h0);
        chk("rst_dmem_be",    32'(dmem_be),  32'h0);
        chk("rst_dmem_wdata", dmem_wdata,    32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // LW 0x100, ack on first REQ cycle
        model_load(3'd3, 32'h100, 32'hAABBCCDD, pd, pb);
        chk("model_lw", pd, 32'hAABBCCDD);
        do_op(1'b0, 3'd3, 32'h100, 32'h0, 0, 32'hAABBCCDD);
        chk("t1_ld_data", ld_data, 32'hAABBCCDD);
        chk("t1_ld_be", 32'(ld_be), 32'hF);
        gap(1);

        // LB / LBU at 0x103
        model_load(3'd0, 32'h103, 32'h80FFEE11, pd, pb);
        chk("model_lb", pd, 32'hFFFFFF80);
        do_op(1'b0, 3'd0, 32'h103, 32'h0, 1, 32'h80FFEE11);
        chk("t2_lb", ld_data, 32'hFFFFFF80);
        do_op(1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h80FFEE11);
        chk("t2_lbu", ld_data, 32'h00000080);

        // SH 0x202
        model_store(3'd1, 32'h202, 32'h00001234, pb, pd);
        chk("model_sh_be", 32'(pb), 32'hC);
        chk("model_sh_wdata", pd, 32'h12341234);
        do_op(1'b1, 3'd1, 32'h202, 32'h00001234, 0, 32'h0);
        chk("t3_ld_hold", ld_data, 32'h00000080);

        // LW 0x101 misaligned
        r0 = req_cycles;
        do_op(1'b0, 3'd3, 32'h101, 32'h0, 0, 32'h0);
        gap(1);
        chk("t4_no_req", 32'(req_cycles - r0), 32'd0);

        // LWL 0x2, ack after 5 wait cycles
        model_load(3'd2, 32'h2, 32'h11223344, pd, pb);
        chk("model_lwl", pd, 32'h33440000);
        r0 = req_cycles;
        do_op(1'b0, 3'd2, 32'h2, 32'h0, 5, 32'h11223344);
        chk("t5_req_cycles", 32'(req_cycles - r0), 32'd6);
        chk("t5_ld_data", ld_data, 32'h33440000);
        chk("t5_ld_be", 32'(ld_be), 32'hC);

`ifdef LSU_TIMEOUT_EN
        r0 = req_cycles;
        do_op(1'b1, 3'd3, 32'h500, 32'hCAFEF00D, 10, 32'h0);
        chk("t6_req_cycles", 32'(req_cycles - r0), 32'd4);
        gap(1);
`endif

        // Reset while in REQ
        begin
            exp_t e;
            e = base(); e.stall = 1'b1;
            step(1'b1, 1'b0, 3'd3, 3'd0, 32'h400, 32'h0, 1'b0, 32'h0, e);
            e = base(); e.stall = 1'b1; e.req = 1'b1; e.addr = 32'h400;
            step(1'b1, 1'b0, 3'd3, 3'd0, 32'h400, 32'h0, 1'b0, 32'h0, e);
            step(1'b1, 1'b0, 3'd3, 3'd0, 32'h400, 32'h0, 1'b0, 32'h0, e);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("rst_mid_req", 32'(dmem_req), 32'h0);
        chk("rst_mid_stall", 32'(stall), 32'h0);
        chk("rst_mid_ld_be", 32'(ld_be), 32'h0);
        m_ld_data = 32'h0;
        m_ld_be   = 4'h0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bit         st;
            logic [2:0] sel;
            st  = 1'($urandom);
            sel = st ? 3'($urandom % 5) : 3'($urandom % 7);
            do_op(st, sel, $urandom, $urandom, int'($urandom % (MAX_WAIT + 1)), $urandom);
            gap(int'($urandom % 3));
        end

        gap(2);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
